// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges WB-stage writes with buffered mul/div results onto one register-file write port.
module writeback_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_Write_register,
    input  logic [31:0] wb_Write_data,
    input  logic        md_valid,
    input  logic [4:0]  md_Write_register,
    input  logic [31:0] md_Write_data,
    output logic        md_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_register,
    input  logic [4:0]  Read_register1,
    input  logic [4:0]  Read_register2,
    output logic        hazard_stall,
    output logic        wb_hold,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [36:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   pending, pend_eff;
    logic [3:0]    starve_cnt, starve_nxt;
    logic          push, pop, sel_wb;
    logic [4:0]    head_reg;
    logic [31:0]   head_data;
    assign head_reg  = mem[rd_ptr][36:32];
    assign head_data = mem[rd_ptr][31:0];
    // Ready looks only at occupancy, so a same-cycle pop never lets a full FIFO accept.
    assign md_ready = reset && (count < (AW+1)'(FIFO_DEPTH));
    assign push     = md_valid && md_ready;
    assign sel_wb   = reset && wb_RegWrite;
    assign pop      = reset && !wb_RegWrite && (count != '0);
    always_comb begin
        Write_register = sel_wb ? wb_Write_register : pop ? head_reg : 5'd0;
        Write_data     = sel_wb ? wb_Write_data : pop ? head_data : 32'd0;
        RegWrite       = (sel_wb || pop) && (Write_register != 5'd0);
        pend_eff       = pending & ~(pop ? (32'd1 << head_reg) : 32'd0);
        hazard_stall   = pend_eff[Read_register1] | pend_eff[Read_register2];
        starve_nxt     = (pop || count == '0) ? 4'd0 :
                         (starve_cnt == 4'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 4'd1;
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {md_Write_register, md_Write_data};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pending    <= '0;
            starve_cnt <= '0;
            wb_hold    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count      <= count + (AW+1)'(push) - (AW+1)'(pop);
            pending    <= (pend_eff | (issue_valid ? (32'd1 << issue_register) : 32'd0)) & ~32'd1;
            starve_cnt <= starve_nxt;
            wb_hold    <= (starve_nxt == 4'(STARVE_LIMIT));
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: randomized and directed stimulus against a queue-based reference model with a scoreboard.
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_RegWrite = 1'b0;
    logic [4:0]  wb_Write_register = '0;
    logic [31:0] wb_Write_data = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_Write_register = '0;
    logic [31:0] md_Write_data = '0;
    logic        md_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_register = '0;
    logic [4:0]  Read_register1 = '0;
    logic [4:0]  Read_register2 = '0;
    logic        hazard_stall, wb_hold, RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_RegWrite(wb_RegWrite), .wb_Write_register(wb_Write_register), .wb_Write_data(wb_Write_data),
        .md_valid(md_valid), .md_Write_register(md_Write_register), .md_Write_data(md_Write_data),
        .md_ready(md_ready), .issue_valid(issue_valid), .issue_register(issue_register),
        .Read_register1(Read_register1), .Read_register2(Read_register2),
        .hazard_stall(hazard_stall), .wb_hold(wb_hold),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data)
    );

    always #5 clk = ~clk;

    typedef struct {logic [4:0] r; logic [31:0] d;} ent_t;
    typedef struct {logic rw; logic [4:0] wr; logic [31:0] wd; logic hz; logic rdy; logic hold;} exp_t;

    ent_t q[$];
    exp_t exp_q[$];
    bit   pend[32];
    int   scnt = 0;
    bit   hold = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    // One clock cycle: drive inputs, then predict outputs from the spec-level model state.
    task automatic cyc(input bit rst, input bit we, input logic [4:0] wr, input logic [31:0] wd,
                       input bit mv, input logic [4:0] mr, input logic [31:0] md,
                       input bit iv, input logic [4:0] ir, input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        ent_t h;
        bit pop, rdy;
        @(posedge clk);
        #1;
        reset = rst; wb_RegWrite = we; wb_Write_register = wr; wb_Write_data = wd;
        md_valid = mv; md_Write_register = mr; md_Write_data = md;
        issue_valid = iv; issue_register = ir; Read_register1 = r1; Read_register2 = r2;
        e = '{default: 0};
        h = '{default: 0};
        if (!rst) begin
            q.delete();
            foreach (pend[i]) pend[i] = 0;
            scnt = 0;
            hold = 0;
        end else begin
            pop = !we && q.size() > 0;
            rdy = q.size() < DEPTH;
            if (pop) h = q[0];
            e.wr   = we ? wr : pop ? h.r : 5'd0;
            e.wd   = we ? wd : pop ? h.d : 32'd0;
            e.rw   = (we || pop) && e.wr != 5'd0;
            e.hz   = (r1 != 0 && pend[r1] && !(pop && h.r == r1)) ||
                     (r2 != 0 && pend[r2] && !(pop && h.r == r2));
            e.rdy  = rdy;
            e.hold = hold;
            scnt = (pop || q.size() == 0) ? 0 : (scnt < LIMIT ? scnt + 1 : scnt);
            hold = (scnt == LIMIT);
            if (pop) begin
                pend[h.r] = 0;
                h = q.pop_front();
            end
            if (mv && rdy) q.push_back('{mr, md});
            if (iv) pend[ir] = 1;
            pend[0] = 0;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("RegWrite", 32'(RegWrite), 32'(e.rw));
            chk("Write_register", 32'(Write_register), 32'(e.wr));
            chk("Write_data", Write_data, e.wd);
            chk("hazard_stall", 32'(hazard_stall), 32'(e.hz));
            chk("md_ready", 32'(md_ready), 32'(e.rdy));
            chk("wb_hold", 32'(wb_hold), 32'(e.hold));
        end
    end

    initial begin
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 1, 5'd7, 32'hdead, 1, 5'd4, 32'h1, 1, 5'd4, 5'd4, 5'd7);
        // wb wins over a buffered result, which drains next idle cycle
        cyc(1, 0, 0, 0, 1, 5'd6, 32'h22222222, 0, 0, 0, 0);
        cyc(1, 1, 5'd5, 32'h11111111, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // pending r8 stalls until its result pops
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5'd8, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd1);
        cyc(1, 0, 0, 0, 1, 5'd8, 32'h88, 0, 0, 5'd2, 5'd8);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd8);
        idle(1);
        // fill while wb busy, then drain in order
        cyc(1, 1, 5'd1, 32'h10, 1, 5'd9, 32'h90, 0, 0, 0, 0);
        cyc(1, 1, 5'd2, 32'h20, 1, 5'd10, 32'hA0, 0, 0, 0, 0);
        cyc(1, 1, 5'd3, 32'h30, 1, 5'd11, 32'hB0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 5'd12, 32'hC0, 0, 0, 0, 0);
        idle(3);
        // starvation drives wb_hold, then a pop clears it
        cyc(1, 0, 0, 0, 1, 5'd13, 32'hD0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 5'd14, 32'(i), 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // register 0 is accepted and popped but never written or pending
        cyc(1, 0, 0, 0, 1, 5'd0, 32'hFF, 1, 5'd0, 5'd0, 5'd0);
        cyc(1, 1, 5'd0, 32'hEE, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        idle(2);
        // reset mid-operation drops buffered results and pending bits
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0);
        cyc(1, 1, 5'd1, 32'h1, 1, 5'd3, 32'h33, 0, 0, 5'd3, 0);
        cyc(1, 1, 5'd1, 32'h2, 1, 5'd3, 32'h34, 0, 0, 5'd3, 0);
        cyc(0, 1, 5'd1, 32'h3, 0, 0, 0, 0, 0, 5'd3, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        idle(2);
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, is the number of buffered multiply/divide results and SHALL be a power of two, 2 or greater.
REQ-002 Parameter STARVE_LIMIT, default 3, is the number of consecutive blocked-drain cycles before wb_hold asserts, range 1-15.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 wb_RegWrite, wb_Write_register, wb_Write_data  in  1/5/32  pipeline WB-stage write request.
REQ-006 md_valid, md_Write_register, md_Write_data  in  1/5/32  multiply/divide result offer.
REQ-007 md_ready  out  1  result accepted when md_valid && md_ready at posedge.
REQ-008 issue_valid, issue_register  in  1/5  long-latency op issued; destination becomes pending.
REQ-009 Read_register1, Read_register2  in  5/5  ID-stage source registers.
REQ-010 hazard_stall  out  1  ID must stall; a source register is pending.
REQ-011 wb_hold  out  1  registered; the pipeline shall present wb_RegWrite=0 next cycle.
REQ-012 RegWrite, Write_register, Write_data  out  1/5/32  single register-file write port.

Function
REQ-013 Accepted md results SHALL enter a FIFO_DEPTH-entry FIFO in order; md_ready = (count < FIFO_DEPTH), based on count only, so a simultaneous pop does not raise ready while full.
REQ-014 Port priority: if wb_RegWrite=1, outputs SHALL be wb_* that cycle (combinational, zero latency) and the FIFO SHALL NOT pop.
REQ-015 If wb_RegWrite=0 and FIFO non-empty, outputs SHALL be the FIFO head, and the FIFO SHALL pop at posedge.
REQ-016 If neither source is active, RegWrite=0, Write_register=0, Write_data=0.
REQ-017 Any write whose target is register 0 SHALL drive RegWrite=0; an md entry targeting register 0 SHALL still be accepted and popped.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-019 Pending scoreboard is 32 bits; bit 0 SHALL always read 0.
REQ-020 issue_valid SHALL set pending[issue_register] at posedge; a pop to register r SHALL clear pending[r] at posedge; if both target r in the same cycle, set wins.
REQ-021 hazard_stall = (pending[Read_register1] or pending[Read_register2]), excluding the register being popped this cycle.
REQ-022 A pending register not being popped stalls; the register file's write bypass covers the pop cycle.
REQ-023 An md result for a register with no pending bit SHALL still be written.
REQ-024 starve_cnt (4 bits) SHALL increment when the FIFO is non-empty and wb_RegWrite=1, saturating at STARVE_LIMIT, and SHALL clear on any pop or when the FIFO is empty.
REQ-025 wb_hold SHALL be registered (starve_cnt == STARVE_LIMIT) and assert the cycle after the limit is reached.
REQ-026 If the pipeline violates wb_hold, wb still wins (REQ-014) with no data loss.

Reset
REQ-027 While reset=0, asynchronously: FIFO empty, pending all 0, starve_cnt=0, wb_hold=0, md_ready=0.
REQ-028 Outputs under reset: RegWrite=0, Write_register=0, Write_data=0, hazard_stall=0.
REQ-029 md_ready SHALL rise in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL discard buffered results and pending bits; no partial write SHALL occur after release.

Verification
REQ-031 wb write r5=0x11111111 while the FIFO holds r6=0x22222222 -> RegWrite r5 that cycle; r6 is written the next cycle when wb is idle.
REQ-032 issue r8; ID reads r8 -> hazard_stall=1; md result r8 popped -> hazard_stall=0 in the pop cycle, and RegWrite r8 is driven in the same cycle.
REQ-033 Push 2 results with wb busy -> md_ready=0 with count=2; wb idle -> pops in order; md_ready returns to 1 after the first pop.
REQ-034 wb busy for 4 consecutive cycles with the FIFO non-empty (STARVE_LIMIT=3) -> wb_hold=1 in cycle 4; wb drops -> pop occurs and wb_hold clears the next cycle.
REQ-035 md result to r0 -> accepted, popped, RegWrite stays 0; issue r0 -> hazard_stall stays 0.
REQ-036 reset=0 with 2 entries buffered and r3 pending -> FIFO empty and pending clear immediately; after release no write to r3 occurs.
